// File: rtl/lfsr_burst_ctrl.sv
// Fibonacci LFSR burst sequencer: loads a seed, streams a requested number of
// LFSR states over valid/ready, pulses done, and reports the first return to
// the seed as the sequence period.
module lfsr_burst_ctrl #(
  parameter int                WIDTH = 4,
  parameter logic [WIDTH-1:0]  TAPS  = 4'b1001,
  parameter int                CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WIDTH-1:0]  seed,
  input  logic [CNT_W-1:0]  nsteps,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  q,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  period
);

  // state | meaning
  // IDLE  | waiting for start; q and period hold results of the last run
  // RUN   | presenting the current LFSR state, advancing on each transfer
  // DONE  | one-cycle completion pulse, err flags a zero seed
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] lfsr, lfsr_nxt, seed_q;
  logic [CNT_W-1:0] remaining, adv_cnt, period_q;
  logic             err_q;
  logic             fb;
  logic             xfer;
  logic             bad_req;

  // Feedback and next LFSR state
  always_comb begin
    fb       = ^(lfsr & TAPS);
    lfsr_nxt = {lfsr[WIDTH-2:0], fb};
  end

  assign xfer    = out_valid && out_ready;
  assign bad_req = (seed == '0) || (nsteps == '0);
  assign q       = lfsr;
  assign period  = period_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and output decode
  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    out_valid = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = bad_req ? DONE : RUN;
      end
      RUN: begin
        out_valid = 1'b1;
        if (out_ready && (remaining == CNT_W'(1))) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        err       = err_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // LFSR, step counters and period capture
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr      <= '0;
      seed_q    <= '0;
      remaining <= '0;
      adv_cnt   <= '0;
      period_q  <= '0;
      err_q     <= 1'b0;
    end else if ((state == IDLE) && start) begin
      err_q    <= (seed == '0);
      period_q <= '0;
      if (!bad_req) begin
        lfsr      <= seed;
        seed_q    <= seed;
        remaining <= nsteps;
        adv_cnt   <= '0;
      end
    end else if (xfer) begin
      lfsr      <= lfsr_nxt;
      remaining <= remaining - CNT_W'(1);
      // Once saturated, any later return exceeds the field and is reported as 0.
      if (adv_cnt != '1) begin
        adv_cnt <= adv_cnt + CNT_W'(1);
        if ((lfsr_nxt == seed_q) && (period_q == '0))
          period_q <= adv_cnt + CNT_W'(1);
      end
    end
  end

endmodule
